// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared widths, opcodes and instruction field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam int OP_LSB  = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 16;
   localparam int FN_LSB  = 0;

   // Logical-immediate ops take a zero-extended immediate.
   function automatic logic imm_is_logical(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/operand_bypass_mux.sv
// ============================================================================
// operand_bypass_mux : R0 zero-check plus write-back match select, one per port
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_bypass_mux #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [ADDR_W-1:0] i_wb_awr,
   input  logic [DATA_W-1:0] i_wb_din,
   input  logic              i_wb_wren,
   output logic [DATA_W-1:0] o_operand,
   output logic              o_wb_hit
);

   logic w_addr_zero;

   assign w_addr_zero = (i_addr == '0);
   assign o_wb_hit    = i_wb_wren && (i_wb_awr == i_addr) && !w_addr_zero;

   always_comb begin
      o_operand = i_rdata;
      if (w_addr_zero)
         o_operand = '0;
      else if (BYPASS_EN && o_wb_hit)
         o_operand = i_wb_din;
   end

endmodule

`default_nettype wire

// File: rtl/decode_operand_stage.sv
// ============================================================================
// decode_operand_stage : decode + reg_file read + one-entry ID/EX register.
// Build option: OPERAND_BYPASS_EN (same-cycle WB bypass; else stall on hazard)
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_operand_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [31:0]       InInstr,
   input  logic              InValid,
   output logic              InReady,
   output logic [ADDR_W-1:0] Ard1,
   output logic [ADDR_W-1:0] Ard2,
   input  logic [DATA_W-1:0] Dout1,
   input  logic [DATA_W-1:0] Dout2,
   input  logic [ADDR_W-1:0] WbAwr,
   input  logic [DATA_W-1:0] WbDin,
   input  logic              WbWrEn,
   input  logic              Flush,
   output logic              ExValid,
   input  logic              ExReady,
   output logic [DATA_W-1:0] ExA,
   output logic [DATA_W-1:0] ExB,
   output logic [DATA_W-1:0] ExImm,
   output logic [ADDR_W-1:0] ExRd,
   output logic [5:0]        ExOpcode,
   output logic [5:0]        ExFunct
);

`ifdef OPERAND_BYPASS_EN
   localparam bit c_bypass = 1'b1;
`else
   localparam bit c_bypass = 1'b0;
`endif

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_rs;
   logic [ADDR_W-1:0] r_rt;
   logic [5:0]        w_op;
   logic [15:0]       w_imm16;
   logic [DATA_W-1:0] w_imm;
   logic [ADDR_W-1:0] w_rd;
   logic [DATA_W-1:0] w_opa;
   logic [DATA_W-1:0] w_opb;
   logic              w_hit1;
   logic              w_hit2;
   logic              w_hazard;
   logic              w_accept;
   logic              w_hold;
   logic              w_wb_live;
   logic              w_unused_shamt;

   assign Ard1           = InInstr[RS_LSB +: ADDR_W];
   assign Ard2           = InInstr[RT_LSB +: ADDR_W];
   assign w_op           = InInstr[OP_LSB +: 6];
   assign w_imm16        = InInstr[IMM_LSB +: IMM_W];
   assign w_unused_shamt = &{1'b0, InInstr[10:6]};

   assign w_imm = imm_is_logical(w_op) ? {{(DATA_W-IMM_W){1'b0}}, w_imm16}
                                       : {{(DATA_W-IMM_W){w_imm16[IMM_W-1]}}, w_imm16};
   assign w_rd  = (w_op == OP_RTYPE) ? InInstr[RD_LSB +: ADDR_W] : InInstr[RT_LSB +: ADDR_W];

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(c_bypass)) u_mux_a (
      .i_addr(Ard1), .i_rdata(Dout1), .i_wb_awr(WbAwr), .i_wb_din(WbDin),
      .i_wb_wren(WbWrEn), .o_operand(w_opa), .o_wb_hit(w_hit1)
   );

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(c_bypass)) u_mux_b (
      .i_addr(Ard2), .i_rdata(Dout2), .i_wb_awr(WbAwr), .i_wb_din(WbDin),
      .i_wb_wren(WbWrEn), .o_operand(w_opb), .o_wb_hit(w_hit2)
   );

   // Without bypass, hold off the read until the conflicting write has committed.
   assign w_hazard  = !c_bypass && InValid && (w_hit1 || w_hit2);
   assign InReady   = (!ExValid || ExReady) && !w_hazard;
   assign w_accept  = InValid && InReady && !Flush;
   assign w_hold    = (r_state == S_FULL) && !ExReady;
   assign w_wb_live = WbWrEn && (WbAwr != '0);

   always_ff @(posedge Clk) begin
      if (Rst)
         r_state <= S_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (Flush)
         w_state_nxt = S_EMPTY;
      else if (w_accept)
         w_state_nxt = S_FULL;
      else if ((r_state == S_FULL) && ExReady)
         w_state_nxt = S_EMPTY;
   end

   always_comb begin
      ExValid = (r_state == S_FULL);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ExA      <= '0;
         ExB      <= '0;
         ExImm    <= '0;
         ExRd     <= '0;
         ExOpcode <= '0;
         ExFunct  <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
      end else if (w_accept) begin
         ExA      <= w_opa;
         ExB      <= w_opb;
         ExImm    <= w_imm;
         ExRd     <= w_rd;
         ExOpcode <= w_op;
         ExFunct  <= InInstr[FN_LSB +: 6];
         r_rs     <= Ard1;
         r_rt     <= Ard2;
      end else if (w_hold) begin
         // Keep stalled operands coherent with the register file.
         if (w_wb_live && (WbAwr == r_rs))
            ExA <= WbDin;
         if (w_wb_live && (WbAwr == r_rt))
            ExB <= WbDin;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decode_operand_stage.sv
// ============================================================================
// tb_decode_operand_stage : directed bench with architectural register model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_operand_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] InInstr;
   logic        InValid;
   logic        InReady;
   logic [4:0]  Ard1, Ard2;
   logic [31:0] Dout1, Dout2;
   logic [4:0]  WbAwr;
   logic [31:0] WbDin;
   logic        WbWrEn;
   logic        Flush;
   logic        ExValid;
   logic        ExReady;
   logic [31:0] ExA, ExB, ExImm;
   logic [4:0]  ExRd;
   logic [5:0]  ExOpcode, ExFunct;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] regs [32];
   logic        started = 1'b0;

   logic        m_valid = 1'b0;
   logic [31:0] m_instr = '0;

   always #5 Clk = ~Clk;

   assign Dout1 = regs[Ard1];
   assign Dout2 = regs[Ard2];

   decode_operand_stage dut (
      .Clk(Clk), .Rst(Rst), .InInstr(InInstr), .InValid(InValid), .InReady(InReady),
      .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
      .WbAwr(WbAwr), .WbDin(WbDin), .WbWrEn(WbWrEn), .Flush(Flush),
      .ExValid(ExValid), .ExReady(ExReady), .ExA(ExA), .ExB(ExB), .ExImm(ExImm),
      .ExRd(ExRd), .ExOpcode(ExOpcode), .ExFunct(ExFunct)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Architectural value of a register; R0 reads as zero whatever the file returns.
   function automatic logic [31:0] arch(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : regs[a];
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
         return {16'h0000, ins[15:0]};
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic logic [4:0] exp_rd(input logic [31:0] ins);
      return (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
   endfunction

   function automatic logic model_ready();
      logic hz;
      hz = InValid && WbWrEn && (WbAwr != 5'd0) &&
           (WbAwr == InInstr[25:21] || WbAwr == InInstr[20:16]);
`ifdef OPERAND_BYPASS_EN
      hz = 1'b0;
`endif
      return (!m_valid || ExReady) && !hz;
   endfunction

   // Register file commit and stage occupancy model.
   always @(posedge Clk) begin : model
      logic rdy;
      started <= 1'b1;
      if (WbWrEn && WbAwr != 5'd0)
         regs[WbAwr] <= WbDin;
      rdy = model_ready();
      if (Rst || Flush)
         m_valid <= 1'b0;
      else if (InValid && rdy) begin
         m_valid <= 1'b1;
         m_instr <= InInstr;
      end else if (m_valid && ExReady)
         m_valid <= 1'b0;
   end

   // A held entry must always reflect the current register contents.
   always @(negedge Clk) begin
      if (started) begin
         chk("exvalid", {31'd0, ExValid}, {31'd0, m_valid});
         if (!Rst)
            chk("inready", {31'd0, InReady}, {31'd0, model_ready()});
         if (m_valid) begin
            chk("exa",    ExA,   arch(m_instr[25:21]));
            chk("exb",    ExB,   arch(m_instr[20:16]));
            chk("eximm",  ExImm, exp_imm(m_instr));
            chk("exrd",   {27'd0, ExRd},     {27'd0, exp_rd(m_instr)});
            chk("exop",   {26'd0, ExOpcode}, {26'd0, m_instr[31:26]});
            chk("exfn",   {26'd0, ExFunct},  {26'd0, m_instr[5:0]});
         end
      end
   end

   task automatic drive(input logic [31:0] ins, input logic iv, input logic we,
                        input logic [4:0] awr, input logic [31:0] din,
                        input logic rdy, input logic fl);
      InInstr = ins; InValid = iv; WbWrEn = we; WbAwr = awr; WbDin = din;
      ExReady = rdy; Flush = fl;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++)
         regs[i] = 32'h0000_0111 * i;
      regs[0]  = 32'h5A5A_5A5A;
      regs[3]  = 32'd32;
      regs[10] = 32'd2;

      // Reset with a valid instruction present
      Rst = 1'b1;
      drive({6'h00, 5'd10, 5'd3, 5'd5, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      tick(); tick();
      chk("rst_exvalid", {31'd0, ExValid}, 32'd0);
      chk("rst_exa", ExA, 32'd0);
      chk("rst_exb", ExB, 32'd0);
      chk("rst_eximm", ExImm, 32'd0);
      Rst = 1'b0;
      InValid = 1'b0;
      #1 chk("rst_inready", {31'd0, InReady}, 32'd1);

      // Plain read: rs=10, rt=3, rd=5, R-type
      drive({6'h00, 5'd10, 5'd3, 5'd5, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk("plain_valid", {31'd0, ExValid}, 32'd1);
      chk("plain_a", ExA, 32'd2);
      chk("plain_b", ExB, 32'd32);
      chk("plain_rd", {27'd0, ExRd}, 32'd5);
      chk("plain_fn", {26'd0, ExFunct}, 32'h20);

      // Stall refresh of rt=3, then a write to R0 that must not land
      drive(32'd0, 1'b0, 1'b1, 5'd3, 32'd99, 1'b0, 1'b0);
      tick();
      chk("refresh_b", ExB, 32'd99);
      chk("refresh_valid", {31'd0, ExValid}, 32'd1);
      drive(32'd0, 1'b0, 1'b1, 5'd0, 32'd77, 1'b0, 1'b0);
      tick();
      chk("r0_b", ExB, 32'd99);
      chk("r0_a", ExA, 32'd2);
      drive(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();
      chk("consume_valid", {31'd0, ExValid}, 32'd0);

      // Same-cycle conflict on rs=3
      drive({6'h00, 5'd3, 5'd4, 5'd7, 5'd0, 6'h21}, 1'b1, 1'b1, 5'd3, 32'd7, 1'b1, 1'b0);
      #1;
`ifdef OPERAND_BYPASS_EN
      chk("conflict_ready", {31'd0, InReady}, 32'd1);
      tick();
`else
      chk("conflict_ready", {31'd0, InReady}, 32'd0);
      tick();
      WbWrEn = 1'b0;
      tick();
`endif
      chk("conflict_a", ExA, 32'd7);
      chk("conflict_valid", {31'd0, ExValid}, 32'd1);

      // Immediates and R0 operand
      drive({6'h0D, 5'd1, 5'd2, 16'h8001}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();
      chk("ori_imm", ExImm, 32'h0000_8001);
      chk("ori_rd", {27'd0, ExRd}, 32'd2);
      drive({6'h08, 5'd0, 5'd6, 16'h8001}, 1'b1, 1'b1, 5'd0, 32'd5, 1'b1, 1'b0);
      tick();
      chk("addi_imm", ExImm, 32'hFFFF_8001);
      chk("addi_a_r0", ExA, 32'd0);
      chk("addi_rd", {27'd0, ExRd}, 32'd6);

      // Flush while full with an incoming instruction
      drive({6'h0E, 5'd4, 5'd9, 16'h1234}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      tick();
      chk("flush_valid", {31'd0, ExValid}, 32'd0);
      drive(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk("flush_nocap", {31'd0, ExValid}, 32'd0);

      // Reset while holding an entry
      drive({6'h00, 5'd10, 5'd3, 5'd5, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      tick();
      InValid = 1'b0;
      Rst = 1'b1;
      tick();
      chk("midrst_valid", {31'd0, ExValid}, 32'd0);
      chk("midrst_a", ExA, 32'd0);
      Rst = 1'b0;
      #1 chk("midrst_ready", {31'd0, InReady}, 32'd1);

      // Mixed traffic checked by the model every cycle
      for (int i = 0; i < 24; i++) begin
         logic [5:0] ops [6];
         logic [5:0] op;
         ops = '{6'h00, 6'h0C, 6'h08, 6'h0D, 6'h0E, 6'h23};
         op = ops[i % 6];
         drive({op, 5'((i * 3) % 8), 5'((i * 5) % 8), 5'((i + 1) % 32), 5'd0, 6'(i)},
               (i % 5) != 4, (i % 3) != 0, 5'((i * 7) % 8), 32'(i * 1000 + 1),
               (i % 4) != 1, i == 13);
         tick();
      end
      drive(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
